id_stage: RTL and testbench

//  Instruction Decode stage of the Chronos RV32I pipeline, directly downstream of fetch.

---
 rtl/chronos_pkg.sv | 53 +++++
 rtl/imm_gen.sv | 43 ++++
 rtl/id_stage.sv | 149 ++++++++++++++
 tb/tb_id_stage.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/chronos_pkg.sv
// Chronos RV32I shared decode definitions.
// Holds the base-opcode constants, the immediate-format enum, the decoded
// word record handed from id_stage to ex_stage, and an opcode legality helper.
package chronos_pkg;

    localparam int unsigned CHRONOS_XLEN = 32;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    typedef enum logic [2:0] {
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J,
        IMM_R
    } imm_type_e;

    typedef struct packed {
        logic [CHRONOS_XLEN-1:0] pc;
        logic [6:0]              opcode;
        logic [2:0]              funct3;
        logic                    funct7b5;
        logic [4:0]              rd;
        logic [4:0]              rs1;
        logic [4:0]              rs2;
        logic [CHRONOS_XLEN-1:0] imm;
        logic                    illegal;
    } dec_word_t;

    // Opcode constants all end in 2'b11, so a compressed-looking word is
    // rejected here without a separate check on instr[1:0].
    function automatic logic opcode_legal(input logic [6:0] opc);
        logic ok;
        case (opc)
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD,
            OPC_STORE, OPC_OP_IMM, OPC_OP, OPC_MISC_MEM, OPC_SYSTEM: ok = 1'b1;
            default:                                                 ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/imm_gen.sv
// Immediate generator for RV32I.
// Classifies the instruction's immediate format from its opcode and builds the
// sign-extended immediate. Purely combinational.
//   instr    in  32            raw instruction word
//   imm_type out imm_type_e    immediate format (IMM_R for R-type and unknown opcodes)
//   imm      out CHRONOS_XLEN  sign-extended immediate, 0 for IMM_R
module imm_gen
    import chronos_pkg::*;
(
    input  logic [31:0]             instr,
    output imm_type_e               imm_type,
    output logic [CHRONOS_XLEN-1:0] imm
);

    always_comb begin
        imm_type = IMM_R;
        case (instr[6:0])
            OPC_LOAD, OPC_OP_IMM, OPC_JALR,
            OPC_MISC_MEM, OPC_SYSTEM:        imm_type = IMM_I;
            OPC_STORE:                       imm_type = IMM_S;
            OPC_BRANCH:                      imm_type = IMM_B;
            OPC_LUI, OPC_AUIPC:              imm_type = IMM_U;
            OPC_JAL:                         imm_type = IMM_J;
            default:                         imm_type = IMM_R;
        endcase
    end

    always_comb begin
        imm = '0;
        unique case (imm_type)
            IMM_I: imm = {{(CHRONOS_XLEN-12){instr[31]}}, instr[31:20]};
            IMM_S: imm = {{(CHRONOS_XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B: imm = {{(CHRONOS_XLEN-13){instr[31]}}, instr[31], instr[7],
                          instr[30:25], instr[11:8], 1'b0};
            IMM_U: imm = {{(CHRONOS_XLEN-32){instr[31]}}, instr[31:12], 12'b0};
            IMM_J: imm = {{(CHRONOS_XLEN-21){instr[31]}}, instr[31], instr[19:12],
                          instr[20], instr[30:21], 1'b0};
            IMM_R: imm = '0;
            default: imm = '0;
        endcase
    end

endmodule

// File: rtl/id_stage.sv
// Chronos RV32I instruction decode stage.
// Decodes {pc, instr} from fetch and holds results in a two-entry skid buffer
// (MAIN drives execute, SKID catches a word that arrives while MAIN stalls).
// if_ready depends only on registered SKID state, never on id_ready.
//   clk, rst            clock, synchronous active-high reset
//   en, flush           global stall (0 freezes state), discard all words
//   if_valid/if_ready   fetch handshake; if_pc, if_instr payload
//   id_valid/id_ready   execute handshake
//   id_pc .. id_illegal decoded fields of the MAIN entry (pc = RST_PC, rest 0 when empty)
module id_stage
    import chronos_pkg::*;
#(
    parameter int unsigned     XLEN   = CHRONOS_XLEN,
    parameter logic [XLEN-1:0] RST_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            flush,
    input  logic            if_valid,
    input  logic [XLEN-1:0] if_pc,
    input  logic [31:0]     if_instr,
    output logic            if_ready,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [XLEN-1:0] id_pc,
    output logic [6:0]      id_opcode,
    output logic [2:0]      id_funct3,
    output logic            id_funct7b5,
    output logic [4:0]      id_rd,
    output logic [4:0]      id_rs1,
    output logic [4:0]      id_rs2,
    output logic [XLEN-1:0] id_imm,
    output logic            id_illegal
);

    imm_type_e               imm_type;
    logic [CHRONOS_XLEN-1:0] imm;
    dec_word_t               dec;

    dec_word_t main_q;
    dec_word_t skid_q;
    logic      main_valid_q;
    logic      skid_valid_q;
    logic      in_fire;
    logic      out_fire;

    imm_gen u_imm_gen (
        .instr    (if_instr),
        .imm_type (imm_type),
        .imm      (imm)
    );

    // Register fields an instruction format does not encode are zeroed so
    // execute never sees a false hazard on bits that are really immediate.
    always_comb begin
        dec          = '0;
        dec.pc       = if_pc;
        dec.opcode   = if_instr[6:0];
        dec.funct3   = if_instr[14:12];
        dec.funct7b5 = if_instr[30];
        dec.illegal  = ~opcode_legal(if_instr[6:0]);
        if (!dec.illegal) begin
            dec.imm = imm;
            unique case (imm_type)
                IMM_R: begin
                    dec.rd  = if_instr[11:7];
                    dec.rs1 = if_instr[19:15];
                    dec.rs2 = if_instr[24:20];
                end
                IMM_I: begin
                    dec.rd  = if_instr[11:7];
                    dec.rs1 = if_instr[19:15];
                end
                IMM_S, IMM_B: begin
                    dec.rs1 = if_instr[19:15];
                    dec.rs2 = if_instr[24:20];
                end
                IMM_U, IMM_J: begin
                    dec.rd  = if_instr[11:7];
                end
                default: ;
            endcase
        end
    end

    assign if_ready = ~skid_valid_q;
    assign in_fire  = if_valid & if_ready & en;
    assign out_fire = main_valid_q & id_ready & en;

    // SKID can only be valid while MAIN is valid, and an in-fire is impossible
    // while SKID is valid, so SKID never needs to be refilled in the same cycle
    // it drains into MAIN.
    always_ff @(posedge clk) begin
        if (rst) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            main_q       <= '0;
            skid_q       <= '0;
        end else if (en) begin
            if (flush) begin
                main_valid_q <= 1'b0;
                skid_valid_q <= 1'b0;
            end else if (!main_valid_q) begin
                if (in_fire) begin
                    main_q       <= dec;
                    main_valid_q <= 1'b1;
                end
            end else if (out_fire) begin
                if (skid_valid_q) begin
                    main_q       <= skid_q;
                    skid_valid_q <= 1'b0;
                end else if (in_fire) begin
                    main_q <= dec;
                end else begin
                    main_valid_q <= 1'b0;
                end
            end else if (in_fire) begin
                skid_q       <= dec;
                skid_valid_q <= 1'b1;
            end
        end
    end

    always_comb begin
        id_valid    = main_valid_q;
        id_pc       = RST_PC;
        id_opcode   = '0;
        id_funct3   = '0;
        id_funct7b5 = 1'b0;
        id_rd       = '0;
        id_rs1      = '0;
        id_rs2      = '0;
        id_imm      = '0;
        id_illegal  = 1'b0;
        if (main_valid_q) begin
            id_pc       = main_q.pc;
            id_opcode   = main_q.opcode;
            id_funct3   = main_q.funct3;
            id_funct7b5 = main_q.funct7b5;
            id_rd       = main_q.rd;
            id_rs1      = main_q.rs1;
            id_rs2      = main_q.rs2;
            id_imm      = main_q.imm;
            id_illegal  = main_q.illegal;
        end
    end

endmodule

// File: tb/tb_id_stage.sv
// Directed testbench for id_stage: decode vector table plus skid, flush,
// stall and reset sequences.
module tb_id_stage;

    logic        clk = 1'b0;
    logic        rst, en, flush, if_valid, id_ready;
    logic [31:0] if_pc, if_instr;
    logic        if_ready, id_valid, id_funct7b5, id_illegal;
    logic [31:0] id_pc, id_imm;
    logic [6:0]  id_opcode;
    logic [2:0]  id_funct3;
    logic [4:0]  id_rd, id_rs1, id_rs2;

    int checks = 0;
    int errors = 0;

    id_stage #(.XLEN(32), .RST_PC(32'h0)) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .flush       (flush),
        .if_valid    (if_valid),
        .if_pc       (if_pc),
        .if_instr    (if_instr),
        .if_ready    (if_ready),
        .id_valid    (id_valid),
        .id_ready    (id_ready),
        .id_pc       (id_pc),
        .id_opcode   (id_opcode),
        .id_funct3   (id_funct3),
        .id_funct7b5 (id_funct7b5),
        .id_rd       (id_rd),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_imm      (id_imm),
        .id_illegal  (id_illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic        f7b5;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic        ill;
    } vec_t;

    vec_t vecs[13];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_word(input string tag, input vec_t v);
        chk({tag, ".valid"},   {31'b0, id_valid},    32'd1);
        chk({tag, ".pc"},      id_pc,                v.pc);
        chk({tag, ".opcode"},  {25'b0, id_opcode},   {25'b0, v.opc});
        chk({tag, ".funct3"},  {29'b0, id_funct3},   {29'b0, v.f3});
        chk({tag, ".f7b5"},    {31'b0, id_funct7b5}, {31'b0, v.f7b5});
        chk({tag, ".rd"},      {27'b0, id_rd},       {27'b0, v.rd});
        chk({tag, ".rs1"},     {27'b0, id_rs1},      {27'b0, v.rs1});
        chk({tag, ".rs2"},     {27'b0, id_rs2},      {27'b0, v.rs2});
        chk({tag, ".imm"},     id_imm,               v.imm);
        chk({tag, ".illegal"}, {31'b0, id_illegal},  {31'b0, v.ill});
    endtask

    task automatic chk_empty(input string tag);
        chk({tag, ".valid"}, {31'b0, id_valid}, 32'd0);
        chk({tag, ".pc"},    id_pc,             32'h0);
        chk({tag, ".imm"},   id_imm,            32'h0);
        chk({tag, ".rd"},    {27'b0, id_rd},    32'd0);
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] instr);
        if_valid = v;
        if_pc    = pc;
        if_instr = instr;
    endtask

    initial begin
        //             pc        instr         opc    f3    f7 rd  rs1 rs2 imm           ill
        vecs[0]  = '{32'h100, 32'hFFF00093, 7'h13, 3'd0, 1, 1,  0,  0,  32'hFFFFFFFF, 0};
        vecs[1]  = '{32'h104, 32'h12345037, 7'h37, 3'd5, 0, 0,  0,  0,  32'h12345000, 0};
        vecs[2]  = '{32'h108, 32'h00112623, 7'h23, 3'd2, 0, 0,  2,  1,  32'h0000000C, 0};
        vecs[3]  = '{32'h10C, 32'h008000EF, 7'h6F, 3'd0, 0, 1,  0,  0,  32'h00000008, 0};
        vecs[4]  = '{32'h110, 32'h00000000, 7'h00, 3'd0, 0, 0,  0,  0,  32'h00000000, 1};
        vecs[5]  = '{32'h114, 32'h00208233, 7'h33, 3'd0, 0, 4,  1,  2,  32'h00000000, 0};
        vecs[6]  = '{32'h118, 32'hFE000EE3, 7'h63, 3'd0, 1, 0,  0,  0,  32'hFFFFFFFC, 0};
        vecs[7]  = '{32'h11C, 32'hFFFFF117, 7'h17, 3'd7, 1, 2,  0,  0,  32'hFFFFF000, 0};
        vecs[8]  = '{32'h120, 32'hFFF00090, 7'h10, 3'd0, 1, 0,  0,  0,  32'h00000000, 1};
        vecs[9]  = '{32'h124, 32'hFF81A283, 7'h03, 3'd2, 1, 5,  3,  0,  32'hFFFFFFF8, 0};
        vecs[10] = '{32'h128, 32'h00008067, 7'h67, 3'd0, 0, 0,  1,  0,  32'h00000000, 0};
        vecs[11] = '{32'h12C, 32'h00000073, 7'h73, 3'd0, 0, 0,  0,  0,  32'h00000000, 0};
        vecs[12] = '{32'h130, 32'h40208233, 7'h33, 3'd0, 1, 4,  1,  2,  32'h00000000, 0};

        rst = 1'b1; en = 1'b1; flush = 1'b0; id_ready = 1'b0;
        drive(1'b0, 32'h0, 32'h0);

        // Reset held two cycles, then idle.
        step();
        step();
        chk_empty("reset");
        chk("reset.if_ready", {31'b0, if_ready}, 32'd1);
        rst = 1'b0;
        step();
        chk_empty("idle");
        chk("idle.if_ready", {31'b0, if_ready}, 32'd1);

        // Decode table streamed back to back with execute always ready.
        id_ready = 1'b1;
        for (int i = 0; i < 13; i++) begin
            drive(1'b1, vecs[i].pc, vecs[i].instr);
            step();
            chk_word($sformatf("vec%0d", i), vecs[i]);
        end
        drive(1'b0, 32'h0, 32'h0);
        step();
        chk_empty("drain");

        // Skid fill: execute stalls, MAIN then SKID fill, third word held off.
        id_ready = 1'b0;
        drive(1'b1, 32'h200, 32'h00000013);
        step();
        chk("skid.w0_pc", id_pc, 32'h200);
        chk("skid.rdy1", {31'b0, if_ready}, 32'd1);
        drive(1'b1, 32'h204, 32'h00208233);
        step();
        chk("skid.rdy0", {31'b0, if_ready}, 32'd0);
        chk("skid.hold_pc", id_pc, 32'h200);
        drive(1'b1, 32'h208, 32'hFE000EE3);
        step();
        chk("skid.hold2_pc", id_pc, 32'h200);
        chk("skid.rdy0b", {31'b0, if_ready}, 32'd0);
        id_ready = 1'b1;
        step();
        chk_word("skid.w1", '{32'h204, 32'h00208233, 7'h33, 3'd0, 0, 4, 1, 2, 32'h0, 0});
        chk("skid.rdy_back", {31'b0, if_ready}, 32'd1);
        step();
        chk_word("skid.w2", '{32'h208, 32'hFE000EE3, 7'h63, 3'd0, 1, 0, 0, 0, 32'hFFFFFFFC, 0});
        drive(1'b0, 32'h0, 32'h0);
        step();
        chk_empty("skid.drain");

        // Flush with both entries full and a word presented.
        id_ready = 1'b0;
        drive(1'b1, 32'h300, 32'h00000013);
        step();
        drive(1'b1, 32'h304, 32'h00000013);
        step();
        drive(1'b1, 32'h308, 32'h00000013);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk_empty("flush.full");
        chk("flush.if_ready", {31'b0, if_ready}, 32'd1);
        drive(1'b0, 32'h0, 32'h0);
        step();
        chk_empty("flush.after");

        // Flush with MAIN full and SKID empty: the accepted-looking word is discarded.
        drive(1'b1, 32'h310, 32'h00000013);
        step();
        drive(1'b1, 32'h314, 32'h00000013);
        flush = 1'b1;
        step();
        flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        chk_empty("flush.main");
        step();
        chk_empty("flush.main2");

        // Global stall with both entries full; flush during stall is ignored.
        drive(1'b1, 32'h400, 32'h00100093);
        step();
        drive(1'b1, 32'h404, 32'h00200113);
        step();
        en = 1'b0;
        id_ready = 1'b1;
        flush = 1'b1;
        drive(1'b1, 32'h408, 32'h00300193);
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("stall%0d.pc", i), id_pc, 32'h400);
            chk($sformatf("stall%0d.rd", i), {27'b0, id_rd}, 32'd1);
            chk($sformatf("stall%0d.rdy", i), {31'b0, if_ready}, 32'd0);
        end
        en = 1'b1;
        flush = 1'b0;
        step();
        chk("stall.res_pc1", id_pc, 32'h404);
        chk("stall.res_rd1", {27'b0, id_rd}, 32'd2);
        step();
        chk("stall.res_pc2", id_pc, 32'h408);
        chk("stall.res_rd2", {27'b0, id_rd}, 32'd3);
        drive(1'b0, 32'h0, 32'h0);
        step();
        chk_empty("stall.drain");

        // Reset overrides a stall.
        id_ready = 1'b0;
        drive(1'b1, 32'h500, 32'h00000013);
        step();
        chk("rst_ovr.pre", id_pc, 32'h500);
        drive(1'b0, 32'h0, 32'h0);
        en = 1'b0;
        rst = 1'b1;
        step();
        chk_empty("rst_ovr");
        chk("rst_ovr.if_ready", {31'b0, if_ready}, 32'd1);
        rst = 1'b0;
        en = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
